// File: rtl/mem_arbiter_if.sv
// Signal bundle between the consumers, the arbiter and the shared memory channel.
// master = consumers + memory model, slave = arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4
);
   logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
   logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
   logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
   logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
   logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
   logic [NUM_CONSUMERS-1:0]                consumer_write_ready;
   logic                                    mem_read_valid;
   logic [ADDR_BITS-1:0]                    mem_read_address;
   logic                                    mem_read_ready;
   logic [DATA_BITS-1:0]                    mem_read_data;
   logic                                    mem_write_valid;
   logic [ADDR_BITS-1:0]                    mem_write_address;
   logic [DATA_BITS-1:0]                    mem_write_data;
   logic                                    mem_write_ready;

   // Handshake: a consumer raises valid and may drop it at any time; once served,
   // ready stays high while valid stays high and falls the cycle after valid is seen low.
   // The memory raises ready for one sampled cycle to complete the outstanding request.
   modport master (
      output consumer_read_valid, consumer_read_address,
      input  consumer_read_ready, consumer_read_data,
      output consumer_write_valid, consumer_write_address, consumer_write_data,
      input  consumer_write_ready,
      input  mem_read_valid, mem_read_address,
      output mem_read_ready, mem_read_data,
      input  mem_write_valid, mem_write_address, mem_write_data,
      output mem_write_ready
   );

   modport slave (
      input  consumer_read_valid, consumer_read_address,
      output consumer_read_ready, consumer_read_data,
      input  consumer_write_valid, consumer_write_address, consumer_write_data,
      output consumer_write_ready,
      output mem_read_valid, mem_read_address,
      input  mem_read_ready, mem_read_data,
      output mem_write_valid, mem_write_address, mem_write_data,
      input  mem_write_ready
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory read/write channel among NUM_CONSUMERS
// requesters; one access in flight at a time, all outputs registered.
module mem_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4,
   parameter int WRITE_ENABLE  = 1
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus,
   output logic         busy,
   output logic [1:0]   dbg_state_o
);
   localparam int PW = $clog2(NUM_CONSUMERS);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ_WAIT  = 2'd1,
      WRITE_WAIT = 2'd2,
      RELAY      = 2'd3
   } state_t;

   state_t                                  state_q, state_d;
   logic [PW-1:0]                           ptr_q, ptr_d;
   logic [PW-1:0]                           gnt_q, gnt_d;
   logic                                    served_wr_q, served_wr_d;
   logic                                    mrv_q, mrv_d;
   logic [ADDR_BITS-1:0]                    mra_q, mra_d;
   logic                                    mwv_q, mwv_d;
   logic [ADDR_BITS-1:0]                    mwa_q, mwa_d;
   logic [DATA_BITS-1:0]                    mwd_q, mwd_d;
   logic [NUM_CONSUMERS-1:0]                rd_rdy_q, rd_rdy_d;
   logic [NUM_CONSUMERS-1:0]                wr_rdy_q, wr_rdy_d;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;

   logic [NUM_CONSUMERS-1:0] pending;
   logic                     found;
   logic [PW-1:0]            pick;
   logic [PW-1:0]            cand;
   logic                     served_valid;

   assign pending = bus.consumer_read_valid |
                    ((WRITE_ENABLE != 0) ? bus.consumer_write_valid : '0);

   // First pending consumer at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
         cand = PW'((int'(ptr_q) + i) % NUM_CONSUMERS);
         if (!found && pending[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign served_valid = served_wr_q ? bus.consumer_write_valid[gnt_q]
                                     : bus.consumer_read_valid[gnt_q];

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      served_wr_d = served_wr_q;
      mrv_d       = mrv_q;
      mra_d       = mra_q;
      mwv_d       = mwv_q;
      mwa_d       = mwa_q;
      mwd_d       = mwd_q;
      rd_rdy_d    = rd_rdy_q;
      wr_rdy_d    = wr_rdy_q;
      rd_data_d   = rd_data_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d = pick;
               // Read wins when a consumer has both pending.
               if (bus.consumer_read_valid[pick]) begin
                  served_wr_d = 1'b0;
                  mrv_d       = 1'b1;
                  mra_d       = bus.consumer_read_address[pick];
                  state_d     = READ_WAIT;
               end else begin
                  served_wr_d = 1'b1;
                  mwv_d       = 1'b1;
                  mwa_d       = bus.consumer_write_address[pick];
                  mwd_d       = bus.consumer_write_data[pick];
                  state_d     = WRITE_WAIT;
               end
            end
         end
         READ_WAIT: begin
            if (bus.mem_read_ready) begin
               mrv_d            = 1'b0;
               rd_data_d[gnt_q] = bus.mem_read_data;
               rd_rdy_d[gnt_q]  = 1'b1;
               state_d          = RELAY;
            end
         end
         WRITE_WAIT: begin
            if (bus.mem_write_ready) begin
               mwv_d           = 1'b0;
               wr_rdy_d[gnt_q] = 1'b1;
               state_d         = RELAY;
            end
         end
         RELAY: begin
            if (!served_valid) begin
               rd_rdy_d = '0;
               wr_rdy_d = '0;
               ptr_d    = (gnt_q == PW'(NUM_CONSUMERS - 1)) ? '0 : gnt_q + 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         served_wr_q <= 1'b0;
         mrv_q       <= 1'b0;
         mra_q       <= '0;
         mwv_q       <= 1'b0;
         mwa_q       <= '0;
         mwd_q       <= '0;
         rd_rdy_q    <= '0;
         wr_rdy_q    <= '0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         served_wr_q <= served_wr_d;
         mrv_q       <= mrv_d;
         mra_q       <= mra_d;
         mwv_q       <= mwv_d;
         mwa_q       <= mwa_d;
         mwd_q       <= mwd_d;
         rd_rdy_q    <= rd_rdy_d;
         wr_rdy_q    <= wr_rdy_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign bus.mem_read_valid       = mrv_q;
   assign bus.mem_read_address     = mra_q;
   assign bus.consumer_read_ready  = rd_rdy_q;
   assign bus.consumer_read_data   = rd_data_q;
   // A read-only channel ties every write-side output low.
   assign bus.mem_write_valid      = (WRITE_ENABLE != 0) ? mwv_q : 1'b0;
   assign bus.mem_write_address    = (WRITE_ENABLE != 0) ? mwa_q : '0;
   assign bus.mem_write_data       = (WRITE_ENABLE != 0) ? mwd_q : '0;
   assign bus.consumer_write_ready = (WRITE_ENABLE != 0) ? wr_rdy_q : '0;
   assign busy                     = (state_q != IDLE);
   assign dbg_state_o              = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;
   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       busy, busy0;
   logic [1:0] dbg_state, dbg_state0;

   mem_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N)) bus ();
   mem_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N)) bus0 ();

   mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N), .WRITE_ENABLE(1)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave), .busy(busy), .dbg_state_o(dbg_state)
   );
   mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N), .WRITE_ENABLE(0)) dut_ro (
      .clk(clk), .reset(reset), .bus(bus0.slave), .busy(busy0), .dbg_state_o(dbg_state0)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int                  m_ptr = 0;
   int                  txn_k = 0;
   bit                  txn_active = 0, txn_write = 0, txn_done = 0;
   logic                e_mrv = 0, e_mwv = 0, e_busy = 0;
   logic [AW-1:0]       e_mra = '0, e_mwa = '0;
   logic [DW-1:0]       e_mwd = '0;
   logic [N-1:0]        e_rrdy = '0, e_wrdy = '0;
   logic [N-1:0][DW-1:0] e_rdata = '0;

   task automatic model_reset();
      m_ptr = 0; txn_active = 0; txn_write = 0; txn_done = 0; txn_k = 0;
      e_mrv = 0; e_mwv = 0; e_busy = 0; e_mra = '0; e_mwa = '0; e_mwd = '0;
      e_rrdy = '0; e_wrdy = '0; e_rdata = '0;
   endtask

   task automatic model_step();
      int k;
      if (!txn_active) begin
         k = -1;
         for (int i = 0; i < N; i++)
            if (k < 0 && (bus.consumer_read_valid[(m_ptr + i) % N] ||
                          bus.consumer_write_valid[(m_ptr + i) % N]))
               k = (m_ptr + i) % N;
         if (k >= 0) begin
            txn_active = 1; txn_done = 0; txn_k = k;
            txn_write  = !bus.consumer_read_valid[k];
            if (txn_write) begin
               e_mwv = 1; e_mwa = bus.consumer_write_address[k]; e_mwd = bus.consumer_write_data[k];
            end else begin
               e_mrv = 1; e_mra = bus.consumer_read_address[k];
            end
         end
      end else if (!txn_done) begin
         if (!txn_write && bus.mem_read_ready) begin
            e_mrv = 0; e_rdata[txn_k] = bus.mem_read_data; e_rrdy[txn_k] = 1; txn_done = 1;
         end else if (txn_write && bus.mem_write_ready) begin
            e_mwv = 0; e_wrdy[txn_k] = 1; txn_done = 1;
         end
      end else if (!(txn_write ? bus.consumer_write_valid[txn_k] : bus.consumer_read_valid[txn_k])) begin
         e_rrdy = '0; e_wrdy = '0; m_ptr = (txn_k + 1) % N; txn_active = 0;
      end
      e_busy = txn_active;
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else model_step();
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", 64'(busy), 64'(e_busy));
         chk("mem_read_valid", 64'(bus.mem_read_valid), 64'(e_mrv));
         if (e_mrv) chk("mem_read_address", 64'(bus.mem_read_address), 64'(e_mra));
         chk("mem_write_valid", 64'(bus.mem_write_valid), 64'(e_mwv));
         if (e_mwv) begin
            chk("mem_write_address", 64'(bus.mem_write_address), 64'(e_mwa));
            chk("mem_write_data", 64'(bus.mem_write_data), 64'(e_mwd));
         end
         chk("consumer_read_ready", 64'(bus.consumer_read_ready), 64'(e_rrdy));
         chk("consumer_write_ready", 64'(bus.consumer_write_ready), 64'(e_wrdy));
         chk("consumer_read_data", 64'(bus.consumer_read_data), 64'(e_rdata));
         chk("one_mem_valid", 64'(!(bus.mem_read_valid && bus.mem_write_valid)), 64'(1));
         chk("one_ready", 64'($countones({bus.consumer_read_ready, bus.consumer_write_ready}) <= 1), 64'(1));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      bus.consumer_read_valid = '0;  bus.consumer_read_address = '0;
      bus.consumer_write_valid = '0; bus.consumer_write_address = '0; bus.consumer_write_data = '0;
      bus.mem_read_ready = 0; bus.mem_read_data = '0; bus.mem_write_ready = 0;
      bus0.consumer_read_valid = '0;  bus0.consumer_read_address = '0;
      bus0.consumer_write_valid = '0; bus0.consumer_write_address = '0; bus0.consumer_write_data = '0;
      bus0.mem_read_ready = 0; bus0.mem_read_data = '0; bus0.mem_write_ready = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      #2 reset = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic rand_drive();
      for (int i = 0; i < N; i++) begin
         if (bus.consumer_read_valid[i]) begin
            if (bus.consumer_read_ready[i] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 31) == 0))
               bus.consumer_read_valid[i] = 0;
         end else if ($urandom_range(0, 3) == 0) bus.consumer_read_valid[i] = 1;
         if (bus.consumer_write_valid[i]) begin
            if (bus.consumer_write_ready[i] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 31) == 0))
               bus.consumer_write_valid[i] = 0;
         end else if ($urandom_range(0, 3) == 0) bus.consumer_write_valid[i] = 1;
         bus.consumer_read_address[i]  = AW'($urandom);
         bus.consumer_write_address[i] = AW'($urandom);
         bus.consumer_write_data[i]    = DW'($urandom);
      end
      bus.mem_read_ready  = ($urandom_range(0, 2) != 0);
      bus.mem_write_ready = ($urandom_range(0, 2) != 0);
      bus.mem_read_data   = DW'($urandom);
   endtask

   // ---------------- directed scenarios + random traffic ----------------
   logic [3:0] exp_q[$];
   bit         pend, reraised, done;
   int         rd_cyc, wr_cyc;

   initial begin
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      cmp_en = 1;
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_mra", 64'(bus.mem_read_address), 64'(0));
      chk("reset_mwa", 64'(bus.mem_write_address), 64'(0));
      chk("reset_rdata", 64'(bus.consumer_read_data), 64'(0));

      // consumer 2 reads 0x10, memory answers 0x5A immediately
      bus.consumer_read_valid[2] = 1; bus.consumer_read_address[2] = 8'h10;
      bus.mem_read_ready = 1; bus.mem_read_data = 8'h5A;
      @(negedge clk);
      chk("r24_mrv", 64'(bus.mem_read_valid), 64'(1));
      chk("r24_mra", 64'(bus.mem_read_address), 64'(8'h10));
      @(negedge clk);
      chk("r24_ready", 64'(bus.consumer_read_ready), 64'(4'b0100));
      chk("r24_data", 64'(bus.consumer_read_data[2]), 64'(8'h5A));
      bus.consumer_read_valid[2] = 0;
      @(negedge clk);
      chk("r24_idle", 64'(busy), 64'(0));
      chk("r24_model_ptr", 64'(m_ptr), 64'(3));

      // all four read at once from ptr=0; consumer 0 comes back after its turn
      do_reset();
      for (int i = 0; i < N; i++) bus.consumer_read_address[i] = AW'(8'h40 + i);
      bus.consumer_read_valid = '1; bus.mem_read_ready = 1;
      exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      pend = 0; reraised = 0;
      for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (pend) begin bus.consumer_read_valid[0] = 1; pend = 0; end
         for (int i = 0; i < N; i++)
            if (bus.consumer_read_ready[i] && bus.consumer_read_valid[i] && exp_q.size() > 0) begin
               chk("r25_order", 64'(i), 64'(exp_q.pop_front()));
               bus.consumer_read_valid[i] = 0;
               if (i == 0 && !reraised) begin reraised = 1; pend = 1; end
            end
      end
      chk("r25_all_served", 64'(exp_q.size()), 64'(0));

      // consumer 1: read and write together, read goes first
      do_reset();
      bus.consumer_read_valid[1] = 1;  bus.consumer_read_address[1] = 8'h20;
      bus.consumer_write_valid[1] = 1; bus.consumer_write_address[1] = 8'h21;
      bus.consumer_write_data[1] = 8'hAB;
      bus.mem_read_ready = 1; bus.mem_write_ready = 1;
      rd_cyc = -1; wr_cyc = -1; done = 0;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk);
         if (bus.mem_read_valid && rd_cyc < 0) begin
            rd_cyc = c; chk("r26_mra", 64'(bus.mem_read_address), 64'(8'h20));
         end
         if (bus.mem_write_valid && wr_cyc < 0) begin
            wr_cyc = c;
            chk("r26_mwa", 64'(bus.mem_write_address), 64'(8'h21));
            chk("r26_mwd", 64'(bus.mem_write_data), 64'(8'hAB));
         end
         if (bus.consumer_read_ready[1])  bus.consumer_read_valid[1] = 0;
         if (bus.consumer_write_ready[1]) bus.consumer_write_valid[1] = 0;
         done = !bus.consumer_read_valid[1] && !bus.consumer_write_valid[1] && !busy;
      end
      chk("r26_finished", 64'(done), 64'(1));
      chk("r26_read_first", 64'(rd_cyc >= 0 && wr_cyc > rd_cyc), 64'(1));

      // consumer 3 served (ptr wraps), then 0 and 3 compete: 0 wins
      bus.consumer_read_valid[3] = 1; bus.consumer_read_address[3] = 8'h33;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (bus.consumer_read_ready[3]) begin bus.consumer_read_valid[3] = 0; done = 1; end
      end
      chk("r27_served3", 64'(done), 64'(1));
      @(negedge clk);
      chk("r27_model_ptr", 64'(m_ptr), 64'(0));
      bus.consumer_read_valid[0] = 1; bus.consumer_read_address[0] = 8'h30;
      bus.consumer_read_valid[3] = 1;
      @(negedge clk);
      chk("r27_grant0", 64'(bus.mem_read_address), 64'(8'h30));

      // reset in READ_WAIT abandons the access
      do_reset();
      bus.consumer_read_valid[2] = 1; bus.consumer_read_address[2] = 8'h77;
      @(negedge clk);
      @(negedge clk);
      chk("r28_in_wait", 64'(bus.mem_read_valid), 64'(1));
      #2 reset = 1;
      #1;
      chk("r28_mrv", 64'(bus.mem_read_valid), 64'(0));
      chk("r28_busy", 64'(busy), 64'(0));
      chk("r28_mra", 64'(bus.mem_read_address), 64'(0));
      @(negedge clk);
      bus.consumer_read_valid[2] = 0;
      reset = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("r28_no_ready", 64'(bus.consumer_read_ready), 64'(0));
      end

      // read-only channel ignores writes
      bus0.consumer_write_valid[0] = 1;
      bus0.mem_write_ready = 1;
      for (int c = 0; c < 5; c++) begin
         bus0.consumer_write_address[0] = AW'($urandom);
         bus0.consumer_write_data[0]    = DW'($urandom);
         @(negedge clk);
         chk("r29_busy", 64'(busy0), 64'(0));
         chk("r29_wr_out", 64'({bus0.mem_write_valid, bus0.mem_write_address,
                                bus0.mem_write_data, bus0.consumer_write_ready}), 64'(0));
         chk("r29_rd_valid", 64'(bus0.mem_read_valid), 64'(0));
      end
      bus0.consumer_write_valid = '0;

      // randomized traffic with occasional asynchronous reset
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rand_drive();
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1;
            @(negedge clk);
            reset = 0;
         end
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
